// File: rtl/pc_gen_pkg.sv
// pc_gen_pkg: shared defaults, FSM state encoding and PC step sizes for pc_gen
package pc_gen_pkg;
  localparam int XLEN_DEF = 32;
  localparam logic [31:0] RESET_VEC_DEF = 32'h0000_0000;
  localparam int EPOCH_W_DEF = 2;
  localparam int STEP_RVC = 2;
  localparam int STEP_STD = 4;
  typedef enum logic [1:0] {BOOT, RUN, HALT} state_e;
endpackage

// File: rtl/pc_redir_arb.sv
// pc_redir_arb: fixed-priority redirect select (valid_i/target_i in; any_o, target_o, misalign_o out), channel 0 wins
module pc_redir_arb
  import pc_gen_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NUM_REDIR = 3,
  parameter int C_EXT = 0
) (
  input  logic [NUM_REDIR-1:0]      valid_i,
  input  logic [NUM_REDIR*XLEN-1:0] target_i,
  output logic                      any_o,
  output logic [XLEN-1:0]           target_o,
  output logic                      misalign_o
);
  always_comb begin
    target_o = '0;
    for (int k = NUM_REDIR - 1; k >= 0; k--)
      if (valid_i[k]) target_o = target_i[k*XLEN +: XLEN];
    any_o = |valid_i;
    misalign_o = (C_EXT != 0) ? target_o[0] : |target_o[1:0];
  end
endmodule

// File: rtl/pc_gen.sv
// pc_gen: fetch PC generator (clk, rst async active-low, redir_*_i, stall_i, fetch_*_i in; fetch_valid_o, pc_o, epoch_o, misalign_*_o out)
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_VEC = RESET_VEC_DEF,
  parameter int NUM_REDIR = 3,
  parameter int EPOCH_W = EPOCH_W_DEF,
  parameter int C_EXT = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REDIR-1:0]      redir_valid_i,
  input  logic [NUM_REDIR*XLEN-1:0] redir_target_i,
  input  logic                      stall_i,
  input  logic                      fetch_ready_i,
  input  logic                      fetch_rvc_i,
  output logic                      fetch_valid_o,
  output logic [XLEN-1:0]           pc_o,
  output logic [EPOCH_W-1:0]        epoch_o,
  output logic                      misalign_o,
  output logic [XLEN-1:0]           misalign_addr_o
);
  state_e st_q, st_d;
  logic [XLEN-1:0] pc_q, pc_d, maddr_q, maddr_d, tgt, step;
  logic [EPOCH_W-1:0] ep_q, ep_d;
  logic mis_q, mis_d, any, bad, fire;
  pc_redir_arb #(.XLEN(XLEN), .NUM_REDIR(NUM_REDIR), .C_EXT(C_EXT)) u_arb (
    .valid_i(redir_valid_i),
    .target_i(redir_target_i),
    .any_o(any),
    .target_o(tgt),
    .misalign_o(bad)
  );
  assign fetch_valid_o = (st_q == RUN) & ~stall_i;
  assign fire = fetch_valid_o & fetch_ready_i;
  always_comb begin
    step = (C_EXT != 0 && fetch_rvc_i) ? XLEN'(STEP_RVC) : XLEN'(STEP_STD);
    pc_d = any ? (bad ? pc_q : tgt) : fire ? pc_q + step : pc_q;
    ep_d = any ? ep_q + 1'b1 : ep_q;
    st_d = any ? (bad ? HALT : RUN) : (st_q == BOOT ? RUN : st_q);
    mis_d = any & bad;
    maddr_d = (any & bad) ? tgt : maddr_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q <= BOOT;
      pc_q <= RESET_VEC;
      ep_q <= '0;
      mis_q <= 1'b0;
      maddr_q <= '0;
    end else begin
      st_q <= st_d;
      pc_q <= pc_d;
      ep_q <= ep_d;
      mis_q <= mis_d;
      maddr_q <= maddr_d;
    end
  end
  assign pc_o = pc_q;
  assign epoch_o = ep_q;
  assign misalign_o = mis_q;
  assign misalign_addr_o = maddr_q;
endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed bench for pc_gen (C_EXT=0 and C_EXT=1 instances) against a behavioural model
module tb_pc_gen;
  logic clk = 1'b0, rst = 1'b0;
  logic [2:0] rv = '0;
  logic [95:0] tg = '0;
  logic stall = 1'b0, ready = 1'b1, rvc = 1'b0;
  logic v_w[2], mis_w[2];
  logic [31:0] pc_w[2], ma_w[2];
  logic [1:0] ep_w[2];
  int errors = 0, checks = 0;
  bit armed = 1'b0;
  int mode[2];
  logic [31:0] mpc[2], maddr[2];
  logic [1:0] mep[2];
  logic mmis[2];
  always #5 clk = ~clk;
  pc_gen #(.C_EXT(0)) u0 (
    .clk(clk), .rst(rst), .redir_valid_i(rv), .redir_target_i(tg), .stall_i(stall),
    .fetch_ready_i(ready), .fetch_rvc_i(rvc), .fetch_valid_o(v_w[0]), .pc_o(pc_w[0]),
    .epoch_o(ep_w[0]), .misalign_o(mis_w[0]), .misalign_addr_o(ma_w[0])
  );
  pc_gen #(.C_EXT(1)) u1 (
    .clk(clk), .rst(rst), .redir_valid_i(rv), .redir_target_i(tg), .stall_i(stall),
    .fetch_ready_i(ready), .fetch_rvc_i(rvc), .fetch_valid_o(v_w[1]), .pc_o(pc_w[1]),
    .epoch_o(ep_w[1]), .misalign_o(mis_w[1]), .misalign_addr_o(ma_w[1])
  );
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask
  // model modes: 0 = boot cycle, 1 = running, 2 = halted on misaligned redirect
  always @(posedge clk or negedge rst) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst) begin
        mode[i] = 0; mpc[i] = 32'h0; mep[i] = 2'd0; mmis[i] = 1'b0; maddr[i] = 32'h0;
      end else begin
        int win;
        logic [31:0] t;
        win = -1;
        for (int k = 2; k >= 0; k--) if (rv[k]) win = k;
        mmis[i] = 1'b0;
        if (win >= 0) begin
          t = tg[win*32 +: 32];
          mep[i] = mep[i] + 2'd1;
          if ((i == 1) ? t[0] : (t[1:0] != 2'b00)) begin
            mmis[i] = 1'b1; maddr[i] = t; mode[i] = 2;
          end else begin
            mpc[i] = t; mode[i] = 1;
          end
        end else begin
          if (mode[i] == 1 && !stall && ready) mpc[i] = mpc[i] + ((i == 1 && rvc) ? 32'd2 : 32'd4);
          if (mode[i] == 0) mode[i] = 1;
        end
      end
    end
  end
  always @(negedge clk) if (armed) begin
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("u%0d_valid", i), {31'd0, v_w[i]}, {31'd0, (mode[i] == 1) && !stall});
      chk($sformatf("u%0d_pc", i), pc_w[i], mpc[i]);
      chk($sformatf("u%0d_epoch", i), {30'd0, ep_w[i]}, {30'd0, mep[i]});
      chk($sformatf("u%0d_misalign", i), {31'd0, mis_w[i]}, {31'd0, mmis[i]});
      chk($sformatf("u%0d_misaddr", i), ma_w[i], maddr[i]);
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    repeat (3) tick();
    armed = 1'b1;
    rst = 1'b1;
    #1 chk("boot_valid", {31'd0, v_w[0]}, 32'd0);
    chk("boot_pc", pc_w[0], 32'h0);
    tick(); chk("run_valid", {31'd0, v_w[0]}, 32'd1); chk("seq0", pc_w[0], 32'h0);
    tick(); chk("seq4", pc_w[0], 32'h4);
    tick(); chk("seq8", pc_w[0], 32'h8);
    stall = 1'b1;
    repeat (3) begin
      tick(); chk("stall_pc", pc_w[0], 32'h8); chk("stall_valid", {31'd0, v_w[0]}, 32'd0);
    end
    stall = 1'b0;
    #1 chk("unstall_valid", {31'd0, v_w[0]}, 32'd1);
    tick(); chk("seqC", pc_w[0], 32'hC);
    ready = 1'b0;
    repeat (3) begin
      tick(); chk("notready_pc", pc_w[0], 32'hC);
    end
    ready = 1'b1;
    tick(); chk("seq10", pc_w[0], 32'h10);
    stall = 1'b1; rv = 3'b110; tg[32 +: 32] = 32'h100; tg[64 +: 32] = 32'h200;
    tick(); rv = '0;
    chk("prio_pc", pc_w[0], 32'h100); chk("prio_epoch", {30'd0, ep_w[0]}, 32'd1);
    stall = 1'b0;
    rv = 3'b001; tg[31:0] = 32'h40;
    tick(); rv = '0; rvc = 1'b1;
    chk("redir40", pc_w[1], 32'h40);
    tick(); rvc = 1'b0;
    chk("rvc_step", pc_w[1], 32'h42); chk("nocext_step", pc_w[0], 32'h44);
    tick(); chk("std_step", pc_w[1], 32'h46); chk("nocext_step2", pc_w[0], 32'h48);
    rv = 3'b001; tg[31:0] = 32'h102;
    tick(); rv = '0;
    chk("mis_pulse", {31'd0, mis_w[0]}, 32'd1); chk("mis_addr", ma_w[0], 32'h102);
    chk("mis_pc", pc_w[0], 32'h48); chk("halt_valid", {31'd0, v_w[0]}, 32'd0);
    chk("cext_aligned", pc_w[1], 32'h102);
    tick(); chk("mis_clear", {31'd0, mis_w[0]}, 32'd0); chk("mis_hold", ma_w[0], 32'h102);
    chk("halt_pc", pc_w[0], 32'h48);
    rv = 3'b001; tg[31:0] = 32'h80;
    tick(); rv = '0;
    chk("resume_pc", pc_w[0], 32'h80); chk("resume_epoch", {30'd0, ep_w[0]}, 32'd0);
    chk("resume_valid", {31'd0, v_w[0]}, 32'd1);
    rv = 3'b100; tg[64 +: 32] = 32'hFFFF_FFFC;
    tick(); rv = '0; chk("wrap_pre", pc_w[0], 32'hFFFF_FFFC);
    tick(); chk("wrap_pc", pc_w[0], 32'h0); chk("wrap_pc1", pc_w[1], 32'h0);
    tick();
    #2 rst = 1'b0;
    #1 chk("async_pc", pc_w[0], 32'h0); chk("async_epoch", {30'd0, ep_w[0]}, 32'd0);
    chk("async_valid", {31'd0, v_w[0]}, 32'd0);
    tick(); rst = 1'b1;
    rv = 3'b010; tg[32 +: 32] = 32'h300;
    tick(); rv = '0; chk("boot_redir", pc_w[0], 32'h300);
    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised program-counter generator; successor to the single-branch PC register at the head of the fetch stage.
- Arbitrates up to NUM_REDIR redirect sources by fixed priority (trap, EX branch, ID jump, ...).
- Steps by 4, or by 2 for compressed instructions when C_EXT=1, and hands PCs to fetch over a valid/ready handshake.
- Tags each PC with an epoch so downstream stages can drop wrong-path fetches; detects misaligned redirect targets.

Parameters:
XLEN, 32, PC and target width
RESET_VEC, 32'h0000_0000, PC value on reset
NUM_REDIR, 3, number of redirect channels; index 0 has highest priority
EPOCH_W, 2, epoch tag width
C_EXT, 0, 1 = compressed ISA: 2-byte step and 2-byte alignment allowed

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
redir_valid_i  in  NUM_REDIR  per-channel redirect request
redir_target_i  in  NUM_REDIR*XLEN  packed targets; channel k at [k*XLEN +: XLEN]
stall_i  in  1  global pipeline stall
fetch_ready_i  in  1  fetch stage accepts the current PC
fetch_rvc_i  in  1  instruction at the accepted PC is compressed; ignored when C_EXT=0
fetch_valid_o  out  1  pc_o/epoch_o are valid for fetch
pc_o  out  XLEN  current fetch PC
epoch_o  out  EPOCH_W  epoch tag of pc_o
misalign_o  out  1  one-cycle pulse: misaligned redirect target seen
misalign_addr_o  out  XLEN  offending target, held until the next misalign

Behaviour:
- Reset (rst=0, asynchronous): pc_o=RESET_VEC, epoch_o=0, misalign_o=0, misalign_addr_o=0, state=BOOT, fetch_valid_o=0. Assertion mid-operation takes effect immediately, regardless of clk.
- States:
  - BOOT: one cycle after reset release, valid=0, then RUN.
  - RUN: normal operation.
  - HALT: entered on a misaligned redirect.
- fetch_valid_o = (state==RUN) & ~stall_i. Combinational on stall_i; registered otherwise.
- fire = fetch_valid_o & fetch_ready_i.
- Redirect select: win = lowest index k with redir_valid_i[k]=1; higher indices are ignored that cycle. Redirects are accepted in every state, including BOOT and under stall_i; a redirect is never lost.
- Alignment: misaligned iff target[1:0]!=0 (C_EXT=0) or target[0]!=0 (C_EXT=1).
- Next-state priority at posedge clk:
  1. Aligned redirect: pc_o<=target; epoch_o<=epoch_o+1 mod 2^EPOCH_W; state<=RUN (BOOT and HALT exit immediately).
  2. Misaligned redirect: pc_o unchanged; epoch_o increments; misalign_o<=1 for one cycle; misalign_addr_o<=target; state<=HALT.
  3. fire with no redirect: pc_o<=pc_o+step (mod 2^XLEN); epoch unchanged.
  4. Otherwise: hold.
- step: 2 if C_EXT=1 and fetch_rvc_i=1 at fire, else 4.
- Wrap-around: pc 32'hFFFF_FFFC + 4 gives 0; no flag.
- fire and redirect in the same cycle: the transfer at the old pc/epoch completes, and the redirect sets the next pc. Fetch must tag the accepted PC with the pre-increment epoch.
- Single-cycle redirect latency: target appears on pc_o the cycle after redir_valid_i.
- HALT: fetch_valid_o=0 and pc_o frozen until an aligned redirect; a further misaligned redirect re-pulses misalign_o.

Decomposition:
- Shared defines/package: XLEN default, RESET_VEC default, state encoding (BOOT/RUN/HALT), EPOCH_W default, step constants 2 and 4.
- One sub-module: pc_redir_arb. Fixed-priority select of NUM_REDIR channels; outputs any_valid, selected target and misaligned flag; purely combinational.
- pc_gen holds the state machine, PC register and epoch counter.

Test Plan:
- Reset, then release with fetch_ready_i=1 and no stall: valid=0 for 1 cycle; pc_o then sequences 0,4,8,C; epoch_o stays 0.
- stall_i=1 for 3 cycles at pc=8: fetch_valid_o=0 and pc_o=8 throughout; sequencing resumes at 8 then C. Repeat with fetch_ready_i=0: same hold.
- redir_valid_i=3'b110 with targets ch1=0x100 and ch2=0x200 during stall: next pc_o=0x100, epoch 0→1, and the 0x200 request is ignored.
- C_EXT=1, fire at pc 0x40 with fetch_rvc_i=1, then 0: pc_o goes 0x42 then 0x46. C_EXT=0, target 0x102: misalign_o pulses, misalign_addr_o=0x102, HALT, valid=0; an aligned redirect to 0x80 then resumes at 0x80 with epoch +2 total.
- pc=0xFFFF_FFFC fires: pc_o=0. Asynchronous reset asserted between clock edges mid-run: pc_o=RESET_VEC and epoch_o=0 before the next edge.
